// File: rtl/pc_unit_if.sv
// Fetch request channel between the PC unit (master) and the instruction fetch stage (slave).
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_addr;

  modport master (
    output fetch_valid,
    output fetch_addr,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    output fetch_ready
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection (trap > redirect > increment), halt/resume FSM.
// Optional RV32C support is enabled by defining PC_COMPRESSED_EN.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no fetch request
// RUN   | fetch request presented on fetch_addr
// HALT  | fetching stopped until resume or trap
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int              INC_BYTES    = 4
) (
  input  logic            clk,
  input  logic            reset,
  pc_unit_if.master       fetch,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            inst_short,
  output logic [XLEN-1:0] pc_prev,
  output logic            misaligned,
  output logic            halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_prev_q, pc_prev_d;
  logic            misaligned_q, misaligned_d;

  logic            accepted;
  logic            redirect_bad;
  logic [XLEN-1:0] inc_amt;

`ifdef PC_COMPRESSED_EN
  assign inc_amt      = inst_short ? XLEN'(2) : XLEN'(INC_BYTES);
  assign redirect_bad = redirect_addr[0];
`else
  logic unused_inst_short;
  assign unused_inst_short = inst_short;
  assign inc_amt           = XLEN'(INC_BYTES);
  assign redirect_bad      = |redirect_addr[1:0];
`endif

  assign fetch.fetch_valid = (state_q == ST_RUN);
  assign fetch.fetch_addr  = pc_q;
  assign accepted          = fetch.fetch_valid & fetch.fetch_ready;

  assign pc_prev    = pc_prev_q;
  assign misaligned = misaligned_q;
  assign halted     = (state_q == ST_HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_prev_d    = pc_prev_q;
    misaligned_d = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (trap_valid) begin
          pc_d = trap_vector;
        end else if (redirect_valid) begin
          if (redirect_bad) begin
            misaligned_d = 1'b1;
          end else begin
            pc_d = redirect_addr;
          end
        end else if (accepted && !stall) begin
          pc_d      = pc_q + inc_amt;
          pc_prev_d = pc_q;
        end
        // A trap in the same cycle as a halt request wins; the core keeps fetching.
        if (halt_req && !trap_valid) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (trap_valid) begin
          pc_d    = trap_vector;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= BOOT_ADDRESS;
      pc_prev_q    <= BOOT_ADDRESS;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_prev_q    <= pc_prev_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random traffic against a reference model.
module tb_pc_unit;
  localparam int          XLEN = 32;
  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall, redirect_valid, trap_valid, halt_req, resume, inst_short;
  logic [31:0] redirect_addr, trap_vector;
  logic [31:0] pc_prev;
  logic        misaligned, halted;

  pc_unit_if #(.XLEN(XLEN)) fif ();

  pc_unit #(.XLEN(XLEN), .BOOT_ADDRESS(BOOT), .INC_BYTES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch          (fif.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .halt_req       (halt_req),
    .resume         (resume),
    .inst_short     (inst_short),
    .pc_prev        (pc_prev),
    .misaligned     (misaligned),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = booting, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_prev;
  logic        m_mis;

  task automatic model_reset();
    m_mode = 0;
    m_pc   = BOOT;
    m_prev = BOOT;
    m_mis  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " fetch_valid"}, 64'(fif.fetch_valid), 64'(m_mode == 1));
    chk({tag, " fetch_addr"},  64'(fif.fetch_addr),  64'(m_pc));
    chk({tag, " pc_prev"},     64'(pc_prev),         64'(m_prev));
    chk({tag, " misaligned"},  64'(misaligned),      64'(m_mis));
    chk({tag, " halted"},      64'(halted),          64'(m_mode == 2));
  endtask

  // Advance one clock: model computes the next PC from the current inputs, DUT is sampled 1 time unit after the edge.
  task automatic tick();
    logic [31:0] n_pc, n_prev;
    int          n_mode;
    logic        n_mis;
    logic        fetching, taken;
    n_pc     = m_pc;
    n_prev   = m_prev;
    n_mode   = m_mode;
    n_mis    = 1'b0;
    fetching = (m_mode == 1);
    taken    = fetching && fif.fetch_ready;
    if (m_mode == 0) begin
      n_mode = 1;
    end else begin
      if (trap_valid)
        n_pc = trap_vector;
      else if (fetching && redirect_valid) begin
        if (redirect_addr % 4 == 0) n_pc = redirect_addr;
        else n_mis = 1'b1;
      end else if (taken && !stall) begin
        n_prev = m_pc;
        n_pc   = m_pc + 32'd4;
      end
      if (fetching) n_mode = (halt_req && !trap_valid) ? 2 : 1;
      else          n_mode = (trap_valid || resume) ? 1 : 2;
    end
    @(posedge clk);
    #1;
    m_pc   = n_pc;
    m_prev = n_prev;
    m_mode = n_mode;
    m_mis  = n_mis;
  endtask

  task automatic idle_inputs();
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_addr   = '0;
    trap_valid      = 1'b0;
    trap_vector     = '0;
    halt_req        = 1'b0;
    resume          = 1'b0;
    inst_short      = 1'b0;
    fif.fetch_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    check_model("reset");
    chk("reset addr", 64'(fif.fetch_addr), 64'h100);

    // Release reset; trap/redirect during BOOT must be ignored.
    reset          = 1'b1;
    trap_valid     = 1'b1;
    trap_vector    = 32'h0000_0500;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0600;
    chk("boot valid low", 64'(fif.fetch_valid), 64'd0);
    tick();
    check_model("boot->run");
    chk("run addr", 64'(fif.fetch_addr), 64'h100);
    chk("run valid", 64'(fif.fetch_valid), 64'd1);
    idle_inputs();

    fif.fetch_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_model("seq");
      chk("seq addr", 64'(fif.fetch_addr), 64'(32'h100 + 32'(4 * i)));
      chk("seq prev", 64'(pc_prev), 64'(32'h100 + 32'(4 * (i - 1))));
    end

    stall = 1'b1;
    tick();
    check_model("stall");
    chk("stall addr", 64'(fif.fetch_addr), 64'h10C);
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0200;
    tick();
    check_model("redir stall");
    chk("redir addr", 64'(fif.fetch_addr), 64'h200);

    stall           = 1'b0;
    fif.fetch_ready = 1'b0;
    redirect_addr   = 32'h0000_0202;
    tick();
    check_model("misalign");
    chk("misalign pulse", 64'(misaligned), 64'd1);
    chk("misalign addr", 64'(fif.fetch_addr), 64'h200);
    redirect_valid = 1'b0;
    tick();
    check_model("misalign end");
    chk("misalign clear", 64'(misaligned), 64'd0);

    trap_valid     = 1'b1;
    trap_vector    = 32'h0000_0080;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0300;
    tick();
    check_model("trap>redir");
    chk("trap addr", 64'(fif.fetch_addr), 64'h80);
    idle_inputs();
    tick();
    check_model("hold no ready");

    halt_req    = 1'b1;
    trap_valid  = 1'b1;
    trap_vector = 32'h0000_0090;
    tick();
    check_model("halt+trap");
    chk("halt+trap run", 64'(halted), 64'd0);
    trap_valid = 1'b0;
    tick();
    check_model("halt");
    chk("halted", 64'(halted), 64'd1);
    chk("halt valid", 64'(fif.fetch_valid), 64'd0);
    halt_req        = 1'b0;
    redirect_valid  = 1'b1;
    redirect_addr   = 32'h0000_0400;
    fif.fetch_ready = 1'b1;
    tick();
    check_model("halt redir ignored");
    chk("halt redir addr", 64'(fif.fetch_addr), 64'h90);
    idle_inputs();
    resume = 1'b1;
    tick();
    check_model("resume");
    resume   = 1'b0;
    halt_req = 1'b1;
    tick();
    check_model("halt2");
    halt_req    = 1'b0;
    trap_valid  = 1'b1;
    trap_vector = 32'h0000_00C0;
    tick();
    check_model("halt trap");
    chk("halt trap addr", 64'(fif.fetch_addr), 64'hC0);

    idle_inputs();
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick();
    redirect_valid  = 1'b0;
    fif.fetch_ready = 1'b1;
    tick();
    check_model("wrap");
    chk("wrap addr", 64'(fif.fetch_addr), 64'h0);
    chk("wrap prev", 64'(pc_prev), 64'hFFFF_FFFC);

    idle_inputs();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_model("reset in halt");
    chk("reset halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1;
    check_model("reset held");
    reset = 1'b1;
    tick();
    check_model("rerun");

    for (int i = 0; i < 3000; i++) begin
      fif.fetch_ready = ($urandom_range(9) < 7);
      stall           = ($urandom_range(9) < 2);
      redirect_valid  = ($urandom_range(9) == 0);
      redirect_addr   = $urandom & (($urandom_range(1) == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      trap_valid      = ($urandom_range(19) == 0);
      trap_vector     = $urandom & 32'hFFFF_FFFC;
      halt_req        = ($urandom_range(19) == 0);
      resume          = ($urandom_range(4) == 0);
      inst_short      = 1'($urandom_range(1));
      tick();
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
